tile_line_fetcher: RTL

Scanline reader for the tile display path. On each line-start pulse it walks one scanline's worth of tile columns. For each column it reads the tile index from the 8 KiB tilemap RAM, then reads the matching 8-pixel pattern byte from the 2 KiB tile ROM (256 tiles × 8 rows, 1 bpp). Pattern bytes go out one per column on a valid/ready stream to the pixel serializer. It drives the read ports (ren/raddr/rdata, 1-cycle registered latency) of both memories; the write ports stay with the host side.

---
 rtl/tile_line_fetcher.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tile_line_fetcher.sv
// tile_line_fetcher
//
// Scanline reader for the tile display path. A line-start pulse walks one
// scanline's worth of tile columns: for each column the tile index is read
// from the tilemap RAM, then the matching 8-pixel pattern byte is read from
// the 1 bpp tile ROM (256 tiles x 8 rows). Each pattern byte is offered on a
// valid/ready stream, one column per beat.
//
// Stream handshake: o_valid/o_data/o_col/o_last are held stable while
// o_valid=1 and i_ready=0; a beat transfers on a rising edge where
// o_valid && i_ready. o_valid never drops without a transfer, except on reset.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_line_start, i_line        fetch request pulse and scanline number
//   o_busy                      fetch in progress (any state but IDLE)
//   o_map_ren/raddr, i_map_rdata  tilemap read port, 1-cycle latency
//   o_rom_ren/raddr, i_rom_rdata  tile ROM read port, 1-cycle latency
//   o_valid, o_data, o_col, o_last, i_ready  pattern byte stream
//   o_state                     current FSM state, for observation

module tile_line_fetcher #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_line_start,
    input  logic [8:0]  i_line,
    output logic        o_busy,
    output logic        o_map_ren,
    output logic [12:0] o_map_raddr,
    input  logic [7:0]  i_map_rdata,
    output logic        o_rom_ren,
    output logic [10:0] o_rom_raddr,
    input  logic [7:0]  i_rom_rdata,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic [6:0]  o_col,
    output logic        o_last,
    input  logic        i_ready,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAP  = 3'd1,
        ROM  = 3'd2,
        CAP  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [9:0]  LINES    = 10'(ROWS * 8);
    localparam logic [12:0] COLS13   = 13'(COLS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);

    state_t      state_q, state_d;
    logic [12:0] base_q, base_d;
    logic [2:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  out_col_q, out_col_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;

    logic        line_ok;
    logic [12:0] line_base;

    // Lines past the last visible tile row are silently dropped.
    assign line_ok   = ({1'b0, i_line} < LINES);
    // Tilemap offset of the first column of this tile row.
    assign line_base = 13'({7'b0, i_line[8:3]}) * COLS13;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        out_col_d   = out_col_q;
        last_d      = last_q;
        valid_d     = valid_q;
        o_map_ren   = 1'b0;
        o_map_raddr = 13'd0;
        o_rom_ren   = 1'b0;
        o_rom_raddr = 11'd0;

        case (state_q)
            IDLE: begin
                if (i_line_start && line_ok) begin
                    base_d  = line_base;
                    row_d   = i_line[2:0];
                    col_d   = 7'd0;
                    state_d = MAP;
                end
            end
            MAP: begin
                o_map_ren   = 1'b1;
                o_map_raddr = base_q + {6'b0, col_q};
                state_d     = ROM;
            end
            ROM: begin
                // Tile index arrives this cycle; pick the row within the tile.
                o_rom_ren   = 1'b1;
                o_rom_raddr = {i_map_rdata, row_q};
                state_d     = CAP;
            end
            CAP: begin
                data_d    = i_rom_rdata;
                out_col_d = col_q;
                last_d    = (col_q == LAST_COL);
                valid_d   = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        col_d   = col_q + 7'd1;
                        state_d = MAP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            base_q    <= 13'd0;
            row_q     <= 3'd0;
            col_q     <= 7'd0;
            data_q    <= 8'd0;
            out_col_q <= 7'd0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            row_q     <= row_d;
            col_q     <= col_d;
            data_q    <= data_d;
            out_col_q <= out_col_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign o_busy  = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_col   = out_col_q;
    assign o_last  = last_q;
    assign o_state = state_q;

endmodule
